// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: word-addressed program counter and fetch sequencer (BOOT/RUN/HALT).
// Define PC_FETCH_RAS_EN to compile in the return-address stack that predicts jr $31 targets.
module pc_fetch_unit #(
  parameter int              PC_W      = 32,
  parameter int              IADDR_W   = 10,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [PC_W-1:0]    fetch_pc,
  output logic [IADDR_W-1:0] instr_addr,
  input  logic               halt,
  input  logic               branch_taken,
  input  logic [15:0]        branch_off,
  input  logic               jump,
  input  logic [25:0]        jump_idx,
  input  logic               call,
  input  logic               ret,
  input  logic [PC_W-1:0]    jr_target,
  output logic [PC_W-1:0]    ras_pred,
  output logic               ras_empty,
  output logic               ras_miss,
  output logic               ras_overflow
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t          state, state_next;
  logic            accept;
  logic            advance;
  logic [PC_W-1:0] pc1;
  logic [PC_W-1:0] pc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (accept && halt) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (state == RUN);
  end

  assign accept  = fetch_valid && fetch_ready;
  assign advance = accept && !halt;
  assign pc1     = fetch_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // Return beats jump beats branch; the RAS never steers the redirect.
  always_comb begin
    if (ret)               pc_next = jr_target;
    else if (jump)         pc_next = {pc1[PC_W-1:26], jump_idx};
    else if (branch_taken) pc_next = pc1 + {{(PC_W-16){branch_off[15]}}, branch_off};
    else                   pc_next = pc1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fetch_pc <= RESET_PC;
    else if (advance) fetch_pc <= pc_next;
  end

  assign instr_addr = fetch_pc[IADDR_W-1:0];

`ifdef PC_FETCH_RAS_EN
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   top_idx;
  logic [CW-1:0]   ras_count;
  logic            ras_full;
  logic            replace_top;
  logic            push_new;

  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CW'(RAS_DEPTH));
  assign ras_pred    = ras_empty ? '0 : ras_mem[top_idx];
  // call+ret on a non-empty stack is pop-then-push, i.e. overwrite the top in place.
  assign replace_top = call && ret && !ras_empty;
  assign push_new    = call && !replace_top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_idx      <= '0;
      ras_count    <= '0;
      ras_miss     <= 1'b0;
      ras_overflow <= 1'b0;
    end else begin
      ras_miss <= advance && ret && (ras_empty || (ras_mem[top_idx] != jr_target));
      if (advance) begin
        if (push_new) begin
          top_idx <= top_idx + AW'(1);
          if (ras_full) ras_overflow <= 1'b1;
          else          ras_count    <= ras_count + CW'(1);
        end else if (ret && !call && !ras_empty) begin
          top_idx   <= top_idx - AW'(1);
          ras_count <= ras_count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && call) ras_mem[replace_top ? top_idx : top_idx + AW'(1)] <= pc1;
  end
`else
  assign ras_pred     = '0;
  assign ras_empty    = 1'b1;
  assign ras_miss     = 1'b0;
  assign ras_overflow = 1'b0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch sequencer replacing the fixed 32-bit PC register at the front of the MIPS core. Holds the word-addressed PC and drives the instruction-memory address. Advances only on a valid/ready fetch handshake, selecting among sequential, branch, jump, call and return targets. Adds a halt state and an optional return-address stack (RAS) that predicts `jr $31` targets and flags mispredictions for later pipelined generations of the core.

## Interface
Parameters:
- `PC_W`, 32, PC width in bits (≥ 27).
- `IADDR_W`, 10, instruction-memory address width (≤ `PC_W`).
- `RAS_DEPTH`, 4, RAS entries (power of two, ≥ 2).
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - `clk` in 1: rising-edge clock.
  - `rst` in 1: asynchronous, active-high reset.
- Fetch handshake:
  - `fetch_ready` in 1: consumer accepts the current instruction this cycle.
  - `fetch_valid` out 1: `fetch_pc` is valid for fetch.
  - `fetch_pc` out `PC_W`: current PC (word address).
  - `instr_addr` out `IADDR_W`: equal to `fetch_pc[IADDR_W-1:0]`.
- Control flow:
  - `halt` in 1: done; sampled on accept.
  - `branch_taken` in 1: conditional branch resolved taken.
  - `branch_off` in 16: signed word offset.
  - `jump` in 1: `j` or `jal`.
  - `jump_idx` in 26: jump word index.
  - `call` in 1: link instruction (`jal`); pushes the RAS.
  - `ret` in 1: `jr $31`.
  - `jr_target` in `PC_W`: register value for `ret`.
- RAS status:
  - `ras_pred` out `PC_W`: RAS top, or 0 when the RAS is empty.
  - `ras_empty` out 1: RAS holds no entries.
  - `ras_miss` out 1: one-cycle misprediction pulse.
  - `ras_overflow` out 1: sticky; set when a push overwrites an entry.

## Operation
- FSM states: `BOOT`, `RUN`, `HALT`.
  - Reset enters `BOOT`.
  - `BOOT` → `RUN` after exactly one cycle.
  - `RUN` → `HALT` on accept with `halt`=1.
  - `HALT` is left only by `rst`.
- `fetch_valid` is 1 only in `RUN`.
- Accept means `fetch_valid && fetch_ready`. Control inputs are ignored on all other cycles, and PC and RAS hold.
- Next PC on accept, in priority order:
  1. `ret`: `jr_target`.
  2. `jump` (with or without `call`): `{pc1[PC_W-1:26], jump_idx}`.
  3. `branch_taken`: `pc1 + sext(branch_off)`.
  4. Otherwise: `pc1`.
  - Here `pc1 = fetch_pc + 1`.
  - All arithmetic is modulo 2^`PC_W`; wrap-around from all-ones to 0 is legal.
- Accept with `halt`=1: PC holds its current value and no RAS update occurs.
- RAS on accept:
  - `call` pushes `pc1`.
  - `ret` pops.
  - `call`+`ret` together: pop then push, so the top is replaced and the count is unchanged.
  - Push when full: circular overwrite of the oldest entry, count stays at `RAS_DEPTH`, `ras_overflow` is set.
  - Pop when empty: no pointer change, and the pop counts as a miss.
- `ras_miss`: on an accept with `ret`=1, `ras_miss` asserts the next cycle iff the RAS was empty or top ≠ `jr_target`. The redirect always uses `jr_target`; the RAS is advisory only.
- Reset values:
  - `fetch_pc` = `RESET_PC`.
  - `fetch_valid` = 0.
  - `ras_pred` = 0.
  - `ras_empty` = 1.
  - `ras_miss` = 0.
  - `ras_overflow` = 0.
  - RAS count = 0; entry contents are don't-care.
- Reset mid-operation: all state clears immediately (asynchronously), with no completion of the pending accept.

## Timing
- `fetch_pc`, FSM and RAS are registered. A new PC is visible in the cycle after the accept.
- Steady state with `fetch_ready` held at 1: one instruction per cycle.
- First valid fetch: the second rising edge after `rst` deasserts (the `BOOT` cycle).
- `instr_addr` is a combinational slice of the `fetch_pc` register.
- `ras_pred` and `ras_empty` reflect the registered RAS state.
- `ras_miss` is registered: high for exactly one cycle after the offending accept.

## Configuration
- `PC_FETCH_RAS_EN` defined:
  - RAS storage and logic are compiled in, as described above.
- `PC_FETCH_RAS_EN` undefined:
  - No RAS storage.
  - `ras_pred`=0, `ras_empty`=1, `ras_miss`=0, `ras_overflow`=0 constantly.
  - `call` and `ret` still redirect as specified; PC behaviour is identical.

## Test plan
- Reset/boot: `RESET_PC`=0x40, `rst` pulse, `fetch_ready`=1 → `fetch_valid`=0 for one cycle, then `fetch_pc` = 0x40, 0x41, 0x42 on consecutive cycles, and `instr_addr`=0x040.
- Stall and branch:
  - `fetch_ready`=0 for 3 cycles at PC 0x10 → PC holds at 0x10 and `branch_taken` is ignored.
  - Then accept with `branch_taken`=1, `branch_off`=0xFFFC → next PC 0x0D.
- Priority: accept at PC 0x20 with `ret`=1, `jump`=1, `branch_taken`=1, `jr_target`=0x300 → next PC 0x300.
- RAS:
  - `call` at PCs 0x5, 0x9, 0xC → `ras_pred`=0xD.
  - `ret` with `jr_target`=0xD → `ras_miss` stays 0 and `ras_pred`=0xA.
  - `ret` with `jr_target`=0x77 → `ras_miss` pulses one cycle.
- Overflow/empty (`RAS_DEPTH`=4):
  - 5 calls → `ras_overflow`=1 (sticky).
  - 5 rets → 4 pops, then `ras_empty`=1 and the fifth `ret` produces a `ras_miss` pulse.
- Halt/wrap:
  - PC 0xFFFFFFFF sequential accept → PC 0x0.
  - Accept with `halt`=1 → `fetch_valid`=0 permanently, PC frozen, until `rst`.
